// File: rtl/bufgce_div_seq_if.sv
// Command handshake between the control requester and the divided-clock sequencer.
interface bufgce_div_seq_if;
    logic       req;
    logic [1:0] cmd;
    logic       ack;
    logic       err;

    modport master (output req, output cmd, input ack, input err);
    modport slave  (input req, input cmd, output ack, output err);
endinterface

// File: rtl/bufgce_div_seq.sv
// Sequencer for the CE/CLR pins of one divided global clock buffer: starts,
// stops and re-phases the divided clock without runt pulses.
// Optional macro BUFGCE_DIV_SEQ_LOCK_EN adds a LOCKED input; losing PLL lock
// aborts start-up and forces a drain/stop of a running clock.
module bufgce_div_seq #(
    parameter int unsigned CLR_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned DRAIN_CYCLES  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef BUFGCE_DIV_SEQ_LOCK_EN
    input  logic            locked,
`endif
    bufgce_div_seq_if.slave bus,
    output logic            ce_o,
    output logic            clr_o,
    output logic            running,
    output logic            busy
);

    localparam int unsigned CW = 8;

    if (CLR_CYCLES < 1 || CLR_CYCLES > 255) begin : g_bad_clr
        $error("CLR_CYCLES must be in 1..255");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain
        $error("DRAIN_CYCLES must be in 1..255");
    end

    localparam logic [CW-1:0] CLR_LOAD    = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES - 1);

    localparam logic [1:0] CMD_START  = 2'b01;
    localparam logic [1:0] CMD_STOP   = 2'b10;
    localparam logic [1:0] CMD_RESYNC = 2'b11;

    typedef enum logic [2:0] {
        ST_STOPPED,
        ST_CLR_HOLD,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cmd_q, cmd_d;
    logic          rearm_q, rearm_d;
    logic          active_q, active_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          accept;
    logic          lock_s;

`ifdef BUFGCE_DIV_SEQ_LOCK_EN
    logic [1:0] lock_sync;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= 2'b00;
        end else begin
            lock_sync <= {lock_sync[0], locked};
        end
    end

    assign lock_s = lock_sync[1];
`else
    assign lock_s = 1'b1;
`endif

    // Next-state, counter and handshake decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        rearm_d  = rearm_q;
        active_d = active_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        if (!bus.req) begin
            rearm_d = 1'b1;
        end

        // A running clock that just lost lock is not open for commands.
        accept = bus.req && rearm_q &&
                 ((state_q == ST_STOPPED) || (state_q == ST_RUN && lock_s));

        unique case (state_q)
            ST_STOPPED: begin
                if (accept) begin
                    rearm_d = 1'b0;
                    cmd_d   = bus.cmd;
                    if (bus.cmd == CMD_START || bus.cmd == CMD_RESYNC) begin
                        if (lock_s) begin
                            state_d  = ST_CLR_HOLD;
                            cnt_d    = CLR_LOAD;
                            active_d = 1'b1;
                        end else begin
                            ack_d = 1'b1;
                            err_d = 1'b1;
                        end
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            ST_CLR_HOLD: begin
                if (!lock_s) begin
                    state_d  = ST_STOPPED;
                    ack_d    = active_q;
                    err_d    = active_q;
                    active_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d  = ST_STOPPED;
                    ack_d    = active_q;
                    err_d    = active_q;
                    active_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d  = ST_RUN;
                    ack_d    = active_q;
                    active_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_DRAIN;
                    cnt_d    = DRAIN_LOAD;
                    active_d = 1'b0;
                end else if (accept) begin
                    rearm_d = 1'b0;
                    cmd_d   = bus.cmd;
                    if (bus.cmd == CMD_STOP || bus.cmd == CMD_RESYNC) begin
                        state_d  = ST_DRAIN;
                        cnt_d    = DRAIN_LOAD;
                        active_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    if (active_q && cmd_q == CMD_RESYNC) begin
                        state_d = ST_CLR_HOLD;
                        cnt_d   = CLR_LOAD;
                    end else begin
                        state_d  = ST_STOPPED;
                        ack_d    = active_q;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STOPPED;
            cnt_q    <= '0;
            cmd_q    <= 2'b00;
            rearm_q  <= 1'b1;
            active_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ce_o     <= 1'b0;
            clr_o    <= 1'b1;
            running  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            rearm_q  <= rearm_d;
            active_q <= active_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            ce_o     <= (state_d == ST_RUN);
            clr_o    <= (state_d == ST_STOPPED) || (state_d == ST_CLR_HOLD);
            running  <= (state_d == ST_RUN);
            busy     <= (state_d == ST_CLR_HOLD) || (state_d == ST_SETTLE) ||
                        (state_d == ST_DRAIN);
        end
    end

    assign bus.ack = ack_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_bufgce_div_seq.sv
// Directed bench for the divided-clock CE/CLR sequencer.
module tb_bufgce_div_seq;

    logic clk = 1'b0;
    logic rst_n;
`ifdef BUFGCE_DIV_SEQ_LOCK_EN
    logic locked;
`endif
    logic ce1, clr1, run1, busy1;
    logic ce2, clr2, run2, busy2;
    int   total = 0;
    int   bad   = 0;

    bufgce_div_seq_if bus1 ();
    bufgce_div_seq_if bus2 ();

    always #5 clk = ~clk;

    bufgce_div_seq u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef BUFGCE_DIV_SEQ_LOCK_EN
        .locked  (locked),
`endif
        .bus     (bus1),
        .ce_o    (ce1),
        .clr_o   (clr1),
        .running (run1),
        .busy    (busy1)
    );

    bufgce_div_seq #(.CLR_CYCLES(1), .SETTLE_CYCLES(3), .DRAIN_CYCLES(2)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef BUFGCE_DIV_SEQ_LOCK_EN
        .locked  (locked),
`endif
        .bus     (bus2),
        .ce_o    (ce2),
        .clr_o   (clr2),
        .running (run2),
        .busy    (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus1.req  = 1'b0;
        bus1.cmd  = 2'b00;
        bus2.req  = 1'b0;
        bus2.cmd  = 2'b00;
`ifdef BUFGCE_DIV_SEQ_LOCK_EN
        locked    = 1'b1;
`endif
        step();
        step();
        chk("rst_ce", 32'(ce1), 0);
        chk("rst_clr", 32'(clr1), 1);
        rst_n = 1'b1;

        // Idle after reset: stopped, no acknowledge.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_ack", 32'(bus1.ack), 0);
        end
        chk("idle_ce", 32'(ce1), 0);
        chk("idle_clr", 32'(clr1), 1);
        chk("idle_run", 32'(run1), 0);
        chk("idle_busy", 32'(busy1), 0);

        // START with REQ held through the acknowledge.
        bus1.req = 1'b1;
        bus1.cmd = 2'b01;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk($sformatf("start_clr_c%0d", k), 32'(clr1), (k <= 4) ? 1 : 0);
            chk($sformatf("start_ce_c%0d", k), 32'(ce1), (k == 13) ? 1 : 0);
            chk($sformatf("start_ack_c%0d", k), 32'(bus1.ack), (k == 13) ? 1 : 0);
            chk($sformatf("start_busy_c%0d", k), 32'(busy1), (k <= 12) ? 1 : 0);
        end
        chk("start_run", 32'(run1), 1);
        chk("start_err", 32'(bus1.err), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("held_req_ack", 32'(bus1.ack), 0);
            chk("held_req_ce", 32'(ce1), 1);
        end
        bus1.req = 1'b0;
        step();

        // START while already running: immediate acknowledge, no change.
        bus1.req = 1'b1;
        bus1.cmd = 2'b01;
        step();
        chk("start_in_run_ack", 32'(bus1.ack), 1);
        chk("start_in_run_ce", 32'(ce1), 1);
        chk("start_in_run_busy", 32'(busy1), 0);
        bus1.req = 1'b0;
        step();
        chk("start_in_run_ack2", 32'(bus1.ack), 0);

        // STOP from RUN.
        bus1.req = 1'b1;
        bus1.cmd = 2'b10;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("stop_ce_c%0d", k), 32'(ce1), 0);
            chk($sformatf("stop_clr_c%0d", k), 32'(clr1), (k == 9) ? 1 : 0);
            chk($sformatf("stop_ack_c%0d", k), 32'(bus1.ack), (k == 9) ? 1 : 0);
        end
        chk("stop_run", 32'(run1), 0);
        bus1.req = 1'b0;
        step();

        // NOP and STOP while stopped: acknowledged next cycle without error.
        bus1.req = 1'b1;
        bus1.cmd = 2'b00;
        step();
        chk("nop_ack", 32'(bus1.ack), 1);
        chk("nop_err", 32'(bus1.err), 0);
        chk("nop_clr", 32'(clr1), 1);
        bus1.req = 1'b0;
        step();
        bus1.req = 1'b1;
        bus1.cmd = 2'b10;
        step();
        chk("stop_idle_ack", 32'(bus1.ack), 1);
        chk("stop_idle_busy", 32'(busy1), 0);
        bus1.req = 1'b0;
        step();

        // Reset asserted during SETTLE aborts the sequence asynchronously.
        bus1.req = 1'b1;
        bus1.cmd = 2'b01;
        for (int k = 1; k <= 7; k++) step();
        chk("pre_rst_clr", 32'(clr1), 0);
        #2;
        rst_n    = 1'b0;
        bus1.req = 1'b0;
        #1;
        chk("async_rst_clr", 32'(clr1), 1);
        chk("async_rst_ce", 32'(ce1), 0);
        chk("async_rst_busy", 32'(busy1), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("post_rst_ack", 32'(bus1.ack), 0);
        end
        chk("post_rst_ce", 32'(ce1), 0);

        // Short-parameter instance: START then RESYNC.
        bus2.req = 1'b1;
        bus2.cmd = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("d2_start_ack_c%0d", k), 32'(bus2.ack), (k == 5) ? 1 : 0);
            chk($sformatf("d2_start_clr_c%0d", k), 32'(clr2), (k == 1) ? 1 : 0);
        end
        bus2.req = 1'b0;
        step();
        bus2.req = 1'b1;
        bus2.cmd = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("resync_ce_c%0d", k), 32'(ce2), (k == 7) ? 1 : 0);
            chk($sformatf("resync_ack_c%0d", k), 32'(bus2.ack), (k == 7) ? 1 : 0);
            chk($sformatf("resync_clr_c%0d", k), 32'(clr2), (k == 3) ? 1 : 0);
        end
        chk("resync_run", 32'(run2), 1);
        bus2.req = 1'b0;
        step();

`ifdef BUFGCE_DIV_SEQ_LOCK_EN
        // START without lock is rejected.
        locked = 1'b0;
        for (int k = 0; k < 3; k++) step();
        bus1.req = 1'b1;
        bus1.cmd = 2'b01;
        step();
        chk("nolock_ack", 32'(bus1.ack), 1);
        chk("nolock_err", 32'(bus1.err), 1);
        chk("nolock_busy", 32'(busy1), 0);
        chk("nolock_clr", 32'(clr1), 1);
        bus1.req = 1'b0;
        step();

        // Regain lock and start, then lose lock while running.
        locked = 1'b1;
        for (int k = 0; k < 3; k++) step();
        bus1.req = 1'b1;
        bus1.cmd = 2'b01;
        for (int k = 1; k <= 13; k++) step();
        chk("lock_start_ack", 32'(bus1.ack), 1);
        chk("lock_start_ce", 32'(ce1), 1);
        bus1.req = 1'b0;
        step();
        locked = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("lockloss_ce_c%0d", k), 32'(ce1), (k <= 2) ? 1 : 0);
            chk($sformatf("lockloss_clr_c%0d", k), 32'(clr1), (k == 11) ? 1 : 0);
            chk($sformatf("lockloss_ack_c%0d", k), 32'(bus1.ack), 0);
        end
        chk("lockloss_run", 32'(run1), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
